// File: rtl/cpu_sequencer_if.sv
// Decoder-side bundle for the run-control sequencer.
// Requests and decoder enables travel master -> slave; gated enables, status and the
// retired-instruction count travel slave -> master. CNT_W sizes instr_count.
interface cpu_sequencer_if #(
   parameter int CNT_W = 16
);
   logic             wait_req;     // instruction reads SW, must wait for a press
   logic             halt_req;     // instruction is HALT
   logic             pcincr_dec;   // decoder PC increment
   logic             w_dec;        // decoder register write enable
   logic             pc_en;        // gated PC increment
   logic             reg_we;       // gated register write enable
   logic             sw_valid;     // SW operand valid this cycle
   logic             halted;       // sequencer is in HALT
   logic [2:0]       state;        // encoded FSM state
   logic [CNT_W-1:0] instr_count;  // retired instructions, saturating

   modport master (
      output wait_req, halt_req, pcincr_dec, w_dec,
      input  pc_en, reg_we, sw_valid, halted, state, instr_count
   );

   modport slave (
      input  wait_req, halt_req, pcincr_dec, w_dec,
      output pc_en, reg_we, sw_valid, halted, state, instr_count
   );
endinterface

// File: rtl/cpu_sequencer.sv
// Purpose: run-control FSM gating decoder PCincr/w; waits on debounced SW8 presses, latches HALT.
// Latency: enables combinational in the current cycle; press pulse at t -> LOAD at t+1;
//          raw button edge -> press pulse after 2 + DB_CYCLES cycles.
// Backpressure: the datapath is stalled (pc_en=reg_we=0) in WAIT_PRESS, WAIT_RELEASE, HALT, STEP_WAIT.
//
// Ports: clk, reset (sync, active-high), sw8/step raw async buttons, bus (cpu_sequencer_if.slave):
//        wait_req, halt_req, pcincr_dec, w_dec in; pc_en, reg_we, sw_valid, halted, state, instr_count out.
// Optional feature macro: SINGLE_STEP_EN (adds the step debouncer and STEP_WAIT gating).
module cpu_sequencer #(
   parameter int DB_CYCLES = 50000,
   parameter int CNT_W     = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            sw8,
   input  logic            step,
   cpu_sequencer_if.slave  bus
);

   typedef enum logic [2:0] {
      RUN          = 3'd0,
      WAIT_PRESS   = 3'd1,
      LOAD         = 3'd2,
      WAIT_RELEASE = 3'd3,
      HALT         = 3'd4,
      STEP_WAIT    = 3'd5
   } state_t;

   localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

`ifdef SINGLE_STEP_EN
   localparam int NB = 2;
   logic [NB-1:0] raw;
   assign raw = {step, sw8};
`else
   localparam int NB = 1;
   logic [NB-1:0] raw;
   logic          step_unused;
   assign raw         = sw8;
   assign step_unused = step;
`endif

   // ---------------------------------------------------------------- debouncers
   logic [NB-1:0] sync1, sync2, lvl, lvl_d, armed;
   logic [CW-1:0] db_cnt [NB];
   logic [1:0]    fill;     // synchroniser holds real samples once this reaches 2
   logic [NB-1:0] press;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
         lvl   <= '0;
         lvl_d <= '0;
         armed <= '0;
         fill  <= 2'd0;
         for (int b = 0; b < NB; b++) db_cnt[b] <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         lvl_d <= lvl;
         if (fill != 2'd2) fill <= fill + 2'd1;
         for (int b = 0; b < NB; b++) begin
            // A press only counts once the button has been seen released after reset,
            // so a button held through reset cannot fire.
            if (fill == 2'd2 && !sync2[b] && !lvl[b]) armed[b] <= 1'b1;
            if (sync2[b] != lvl[b]) begin
               if (db_cnt[b] == LAST) begin
                  lvl[b]    <= sync2[b];
                  db_cnt[b] <= '0;
               end else begin
                  db_cnt[b] <= db_cnt[b] + CW'(1);
               end
            end else begin
               db_cnt[b] <= '0;
            end
         end
      end
   end

   assign press = armed & lvl & ~lvl_d;

   logic sw_press, sw_rel;
   assign sw_press = press[0];
   assign sw_rel   = lvl_d[0] & ~lvl[0];

`ifdef SINGLE_STEP_EN
   logic step_press, step_go_q;
   assign step_press = press[1];

   // RUN may execute only in the cycle right after a step press.
   always_ff @(posedge clk) begin
      if (reset) step_go_q <= 1'b0;
      else       step_go_q <= step_press;
   end
`endif

   // ---------------------------------------------------------------- FSM
   state_t state_q, state_d;
   logic   pc_en_c, reg_we_c, sw_valid_c, halted_c;

   always_ff @(posedge clk) begin
      if (reset) state_q <= RUN;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      pc_en_c    = 1'b0;
      reg_we_c   = 1'b0;
      sw_valid_c = 1'b0;
      halted_c   = 1'b0;
      case (state_q)
         RUN: begin
            if (bus.halt_req) begin
               state_d = HALT;
            end else if (bus.wait_req) begin
               state_d = WAIT_PRESS;
`ifdef SINGLE_STEP_EN
            end else if (step_go_q) begin
               pc_en_c  = bus.pcincr_dec;
               reg_we_c = bus.w_dec;
               if (bus.pcincr_dec) state_d = STEP_WAIT;
`else
            end else begin
               pc_en_c  = bus.pcincr_dec;
               reg_we_c = bus.w_dec;
`endif
            end
         end
         WAIT_PRESS: begin
            if (sw_press) state_d = LOAD;
         end
         LOAD: begin
            sw_valid_c = 1'b1;
            pc_en_c    = bus.pcincr_dec;
            reg_we_c   = bus.w_dec;
            state_d    = WAIT_RELEASE;
         end
         WAIT_RELEASE: begin
            if (sw_rel) state_d = RUN;
         end
         HALT: begin
            halted_c = 1'b1;
         end
`ifdef SINGLE_STEP_EN
         STEP_WAIT: begin
            if (step_press) state_d = RUN;
         end
`endif
         default: state_d = RUN;
      endcase
      // Reset aborts whatever is in flight: nothing is written or retired this cycle.
      if (reset) begin
         pc_en_c    = 1'b0;
         reg_we_c   = 1'b0;
         sw_valid_c = 1'b0;
         halted_c   = 1'b0;
      end
   end

   // ---------------------------------------------------------------- retired counter
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (reset)
         cnt_q <= '0;
      else if (pc_en_c && cnt_q != {CNT_W{1'b1}})
         cnt_q <= cnt_q + CNT_W'(1);
   end

   assign bus.pc_en       = pc_en_c;
   assign bus.reg_we      = reg_we_c;
   assign bus.sw_valid    = sw_valid_c;
   assign bus.halted      = halted_c;
   assign bus.state       = reset ? 3'd0 : state_q;
   assign bus.instr_count = reset ? '0 : cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

   logic clk = 1'b0;
   logic reset, sw8, step, reset3;
   logic tie0;

   always #5 clk = ~clk;

   cpu_sequencer_if #(.CNT_W(16)) bus ();
   cpu_sequencer_if #(.CNT_W(3))  bus3 ();

   cpu_sequencer #(.DB_CYCLES(4), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .sw8(sw8), .step(step), .bus(bus)
   );

   cpu_sequencer #(.DB_CYCLES(4), .CNT_W(3)) u_sat (
      .clk(clk), .reset(reset3), .sw8(tie0), .step(tie0), .bus(bus3)
   );

   // inputs {rst, wait, halt, pcincr, w, sw8}; exp {pc_en, reg_we, sw_valid, halted, state, count}
   typedef struct {
      logic        rst, wt, hl, pc, we, sw;
      logic [22:0] exp;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];
   int   int_q[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic add(input int n, input logic [5:0] in, input logic [3:0] en,
                      input logic [2:0] st, input int cnt);
      for (int i = 0; i < n; i++) begin
         vec_t v;
         {v.rst, v.wt, v.hl, v.pc, v.we, v.sw} = in;
         v.exp = {en, st, 16'(cnt + (en[3] ? i : 0))};
         tbl.push_back(v);
      end
   endtask

   task automatic check(input string name, input int idx, input logic [22:0] got,
                        input logic [22:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s[%0d] got=%h want=%h", name, idx, got, want);
      end
   endtask

   // One table row = one clock cycle: drive after posedge, compare at negedge.
   task automatic run_row(input vec_t v, input int idx);
      vec_t e;
      reset          = v.rst;
      bus.wait_req   = v.wt;
      bus.halt_req   = v.hl;
      bus.pcincr_dec = v.pc;
      bus.w_dec      = v.we;
      sw8            = v.sw;
      exp_q.push_back(v);
      @(negedge clk);
      e = exp_q.pop_front();
      check("row", idx, {bus.pc_en, bus.reg_we, bus.sw_valid, bus.halted,
                         bus.state, bus.instr_count}, e.exp);
      @(posedge clk); #1;
   endtask

   task automatic step_seg(input logic lvl, input int n, inout int pulses);
      for (int i = 0; i < n; i++) begin
         step = lvl;
         @(negedge clk);
         if (bus.pc_en) pulses++;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int pulses;
      int want;
      reset = 1'b1; sw8 = 1'b0; step = 1'b0; tie0 = 1'b0; reset3 = 1'b1;
      bus.wait_req = 1'b0; bus.halt_req = 1'b0; bus.pcincr_dec = 1'b0; bus.w_dec = 1'b0;
      bus3.wait_req = 1'b0; bus3.halt_req = 1'b0; bus3.pcincr_dec = 1'b1; bus3.w_dec = 1'b1;
      @(posedge clk); #1;

      // reset gating, then free run
      add(2,  6'b100110, 4'b0000, 3'd0, 0);
      add(5,  6'b000110, 4'b1100, 3'd0, 0);
      add(1,  6'b000000, 4'b0000, 3'd0, 5);
      // wait_req with sw8 raised and held: 6 cycles WAIT_PRESS, 1 LOAD, release, RUN
      add(1,  6'b010111, 4'b0000, 3'd0, 5);
      add(6,  6'b010111, 4'b0000, 3'd1, 5);
      add(1,  6'b010111, 4'b1110, 3'd2, 5);
      add(2,  6'b000111, 4'b0000, 3'd3, 6);
      add(7,  6'b000110, 4'b0000, 3'd3, 6);
      add(1,  6'b000110, 4'b1100, 3'd0, 6);
      // glitching sw8 never produces a press
      add(1,  6'b010110, 4'b0000, 3'd0, 7);
      for (int r = 0; r < 3; r++) begin
         add(3, 6'b010111, 4'b0000, 3'd1, 7);
         add(1, 6'b010110, 4'b0000, 3'd1, 7);
      end
      add(2,  6'b010110, 4'b0000, 3'd1, 7);
      // reset mid-WAIT, then halt beats wait; presses ignored in HALT
      add(1,  6'b110110, 4'b0000, 3'd0, 0);
      add(1,  6'b011110, 4'b0000, 3'd0, 0);
      add(3,  6'b000110, 4'b0001, 3'd4, 0);
      add(10, 6'b000111, 4'b0001, 3'd4, 0);
      add(3,  6'b000110, 4'b0001, 3'd4, 0);
      add(1,  6'b100110, 4'b0000, 3'd0, 0);
      add(2,  6'b000110, 4'b1100, 3'd0, 0);
      // sw8 held through reset: no press until released and pressed again
      add(1,  6'b100111, 4'b0000, 3'd0, 0);
      add(1,  6'b010111, 4'b0000, 3'd0, 0);
      add(12, 6'b010111, 4'b0000, 3'd1, 0);
      add(9,  6'b010110, 4'b0000, 3'd1, 0);
      add(7,  6'b010111, 4'b0000, 3'd1, 0);
      add(1,  6'b010111, 4'b1110, 3'd2, 0);
      add(7,  6'b000110, 4'b0000, 3'd3, 1);
      add(2,  6'b000110, 4'b1100, 3'd0, 1);

      for (int i = 0; i < tbl.size(); i++) run_row(tbl[i], i);

      // saturation with CNT_W=3: count climbs to 7 and holds
      for (int i = 0; i < 12; i++) begin
         reset3 = 1'b0;
         int_q.push_back((i < 7) ? i : 7);
         @(negedge clk);
         check("sat_cnt", i, 23'(bus3.instr_count), 23'(int_q.pop_front()));
         check("sat_pc", i, 23'(bus3.pc_en), 23'(1));
         @(posedge clk); #1;
      end

      // step button: ignored by default, gates RUN when single-step is built in
      bus.wait_req = 1'b0; bus.halt_req = 1'b0; bus.pcincr_dec = 1'b1; bus.w_dec = 1'b1;
      sw8 = 1'b0; step = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;

      pulses = 0;
`ifdef SINGLE_STEP_EN
      want = 0;
`else
      want = 10;
`endif
      int_q.push_back(want);
      step_seg(1'b0, 10, pulses);
      check("step_idle", 0, 23'(pulses), 23'(int_q.pop_front()));

      pulses = 0;
`ifdef SINGLE_STEP_EN
      want = 3;
`else
      want = 54;
`endif
      int_q.push_back(want);
      for (int p = 0; p < 3; p++) begin
         step_seg(1'b1, 8, pulses);
         step_seg(1'b0, 10, pulses);
      end
      check("step_three", 0, 23'(pulses), 23'(int_q.pop_front()));

      pulses = 0;
`ifdef SINGLE_STEP_EN
      want = 1;
`else
      want = 50;
`endif
      int_q.push_back(want);
      step_seg(1'b1, 40, pulses);
      step_seg(1'b0, 10, pulses);
      check("step_held", 0, 23'(pulses), 23'(int_q.pop_front()));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
